// File: rtl/sub_seq_16_pkg.sv
// Shared arithmetic package for the sequential subtractor:
// state encoding, default geometry and counter sizing helper.
package sub_seq_16_pkg;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_e;

   localparam int DEF_WIDTH = 16;
   localparam int DEF_SLICE = 4;
   localparam int DEF_NS    = DEF_WIDTH / DEF_SLICE;

   function automatic int cnt_w(input int ns);
      return (ns > 1) ? $clog2(ns) : 1;
   endfunction

   localparam int CNT_W = cnt_w(DEF_NS);

endpackage

// File: rtl/sub_rca_4.sv
// Combinational 4-bit ripple-borrow subtractor:
// {borrow_out, diff} = a - b - borrow_in.
module sub_rca_4 (
   output logic       borrow_out,
   output logic [3:0] diff,
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       borrow_in
);

   logic [4:0] br;

   assign br[0] = borrow_in;

   for (genvar i = 0; i < 4; i++) begin : g_bit
      assign diff[i]  = a[i] ^ b[i] ^ br[i];
      assign br[i+1]  = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br[i]);
   end

   assign borrow_out = br[4];

endmodule

// File: rtl/sub_seq_16.sv
// Multi-cycle subtractor: one 4-bit slice per clock, LSB first,
// with a single registered borrow chaining the slices.
module sub_seq_16
   import sub_seq_16_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SLICE = DEF_SLICE
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             borrow_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             zero,
   output logic             ovf
);

   localparam int NS  = WIDTH / SLICE;
   localparam int CW  = cnt_w(NS);
   localparam int MSB = WIDTH - 1;

   state_e           state;
   state_e           state_n;
   logic [CW-1:0]    cnt;
   logic             brw;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] diff_q;

   logic       s_bo;
   logic [3:0] s_d;

   // Single slice datapath shared across cycles, steered by the counter.
   sub_rca_4 u_rca (
      .borrow_out (s_bo),
      .diff       (s_d),
      .a          (a_q[cnt*SLICE +: 4]),
      .b          (b_q[cnt*SLICE +: 4]),
      .borrow_in  (brw)
   );

   always_comb begin
      state_n = state;
      unique case (state)
         IDLE: if (in_valid) state_n = BUSY;
         BUSY: if (cnt == CW'(NS - 1)) state_n = DONE;
         DONE: if (out_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cnt    <= '0;
         brw    <= 1'b0;
         a_q    <= '0;
         b_q    <= '0;
         diff_q <= '0;
      end else begin
         state <= state_n;
         unique case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q <= a;
                  b_q <= b;
                  brw <= borrow_in;
                  cnt <= '0;
               end
            end
            BUSY: begin
               diff_q[cnt*SLICE +: 4] <= s_d;
               brw <= s_bo;
               cnt <= cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Status flags are only presented while the result is offered.
   assign in_ready   = (state == IDLE);
   assign out_valid  = (state == DONE);
   assign diff       = diff_q;
   assign borrow_out = out_valid & brw;
   assign zero       = out_valid & ~|diff_q;
   assign ovf        = out_valid & (a_q[MSB] ^ b_q[MSB])
                       & (diff_q[MSB] ^ a_q[MSB]);

endmodule

// File: tb/tb_sub_seq_16.sv
// Directed bench for sub_seq_16: arithmetic model, per-cycle
// output compare, literal pins, backpressure and reset cases.
module tb_sub_seq_16;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic [15:0] b;
   logic        borrow_in;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] diff;
   logic        borrow_out;
   logic        zero;
   logic        ovf;

   int tests;
   int fails;

   logic [15:0] exp_d;
   logic        exp_bo;
   logic        exp_z;
   logic        exp_ovf;

   sub_seq_16 dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .a          (a),
      .b          (b),
      .borrow_in  (borrow_in),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .diff       (diff),
      .borrow_out (borrow_out),
      .zero       (zero),
      .ovf        (ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Full-width arithmetic reference
   task automatic model(input logic [15:0] x, input logic [15:0] y,
                        input logic bi);
      logic [16:0] r;
      r       = {1'b0, x} - {1'b0, y} - 17'(bi);
      exp_d   = r[15:0];
      exp_bo  = r[16];
      exp_z   = (r[15:0] == 16'h0);
      exp_ovf = (x[15] ^ y[15]) & (r[15] ^ x[15]);
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         chk("cmp_diff", int'(diff), int'(exp_d));
         chk("cmp_borrow", int'(borrow_out), int'(exp_bo));
         chk("cmp_zero", int'(zero), int'(exp_z));
         chk("cmp_ovf", int'(ovf), int'(exp_ovf));
         chk("cmp_in_ready", int'(in_ready), 0);
      end
   end

   // Present operands, wait for acceptance, then scramble the inputs.
   task automatic issue(input logic [15:0] x, input logic [15:0] y,
                        input logic bi);
      int n;
      model(x, y, bi);
      in_valid  = 1'b1;
      a         = x;
      b         = y;
      borrow_in = bi;
      n = 0;
      while (!in_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) chk("accept_timeout", 0, 1);
      @(posedge clk);
      #1;
      in_valid  = 1'b0;
      a         = 16'($urandom);
      b         = 16'($urandom);
      borrow_in = 1'($urandom);
   endtask

   task automatic wait_done(input string name, input logic [15:0] ld,
                            input logic lbo, input logic lz,
                            input logic lovf);
      int lat;
      lat = 0;
      while (lat < 20) begin
         @(posedge clk);
         lat++;
         #1;
         if (out_valid) break;
      end
      chk({name, "_latency"}, lat, 4);
      chk({name, "_diff"}, int'(diff), int'(ld));
      chk({name, "_borrow"}, int'(borrow_out), int'(lbo));
      chk({name, "_zero"}, int'(zero), int'(lz));
      chk({name, "_ovf"}, int'(ovf), int'(lovf));
   endtask

   // Stall with in_valid noise, then hand the result off.
   task automatic release_out(input int stall);
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         a        = 16'($urandom);
         b        = 16'($urandom);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      chk("release_valid", int'(out_valid), 0);
      chk("release_ready", int'(in_ready), 1);
   endtask

   initial begin
      tests     = 0;
      fails     = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      a         = '0;
      b         = '0;
      borrow_in = 1'b0;
      exp_d     = '0;
      exp_bo    = 1'b0;
      exp_z     = 1'b0;
      exp_ovf   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_diff", int'(diff), 0);
      chk("rst_borrow", int'(borrow_out), 0);
      chk("rst_zero", int'(zero), 0);
      chk("rst_ovf", int'(ovf), 0);
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_ready", int'(in_ready), 1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      issue(16'h1234, 16'h0234, 1'b0);
      wait_done("basic", 16'h1000, 1'b0, 1'b0, 1'b0);
      release_out(0);

      issue(16'h0000, 16'h0001, 1'b0);
      wait_done("underflow", 16'hFFFF, 1'b1, 1'b0, 1'b0);
      release_out(0);

      issue(16'h8000, 16'h0001, 1'b0);
      wait_done("sovf", 16'h7FFF, 1'b0, 1'b0, 1'b1);
      release_out(0);

      issue(16'h0005, 16'h0005, 1'b0);
      wait_done("zero", 16'h0000, 1'b0, 1'b1, 1'b0);
      release_out(0);

      issue(16'h0005, 16'h0005, 1'b1);
      wait_done("bin", 16'hFFFF, 1'b1, 1'b0, 1'b0);
      release_out(0);

      issue(16'h7FFF, 16'hFFFF, 1'b0);
      wait_done("bp", 16'h8000, 1'b1, 1'b0, 1'b1);
      release_out(10);

      // Release and new request in the same cycle: no accept yet.
      issue(16'h0F0F, 16'h00FF, 1'b0);
      wait_done("ovl_a", 16'h0E10, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      a         = 16'h1000;
      b         = 16'h2000;
      borrow_in = 1'b0;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("ovl_idle_valid", int'(out_valid), 0);
      chk("ovl_idle_ready", int'(in_ready), 1);
      issue(16'h1000, 16'h2000, 1'b0);
      wait_done("ovl_b", 16'hF000, 1'b1, 1'b0, 1'b0);
      release_out(0);

      // Reset during the second BUSY cycle.
      issue(16'hABCD, 16'h1234, 1'b0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_diff", int'(diff), 0);
      chk("mid_rst_borrow", int'(borrow_out), 0);
      chk("mid_rst_zero", int'(zero), 0);
      chk("mid_rst_ovf", int'(ovf), 0);
      chk("mid_rst_valid", int'(out_valid), 0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("mid_rst_ready", int'(in_ready), 1);
      @(negedge clk);
      issue(16'hFFFF, 16'h0001, 1'b0);
      wait_done("post_rst", 16'hFFFE, 1'b0, 1'b0, 1'b0);
      release_out(0);

      repeat (2) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
